hc595_frame_capture: RTL and testbench

Receive-side model of the 74HC595 LED-matrix link. The block oversamples the serial shift-register lines (ds, shcp, stcp, mr, oe) and the one-hot row-select bus on the system clock. It reconstructs the 24-stage shift chain and its storage latch, and assembles the column bytes shown on each row into a complete 8x8 frame. It sits beside the matrix driver: as a capture and self-check block in hardware, and as the scoreboard front end in simulation.

---
 rtl/hc595_frame_capture.sv | 164 ++++++++++++++++
 tb/tb_hc595_frame_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_frame_capture.sv
// hc595_frame_capture
// Receive-side model of a 74HC595 LED-matrix link. Oversamples the serial
// shift-register pins and the row-select bus, rebuilds the 24-stage shift
// chain and its storage latch, and assembles the per-row column bytes into
// a complete 8x8 frame that is published once every row has been seen.
module hc595_frame_capture (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        mr,
  input  logic        oe,
  input  logic [7:0]  rows_in,
  output logic [23:0] latch_out,
  output logic [4:0]  shift_count,
  output logic [63:0] frame_out,
  output logic        frame_valid,
  output logic        row_err
);

  // Pin vector ordering inside the synchronizers: {ds, shcp, stcp, mr, oe}
  localparam int PinDs   = 4;
  localparam int PinShcp = 3;
  localparam int PinStcp = 2;
  localparam int PinMr   = 1;
  localparam int PinOe   = 0;

  logic [4:0]  pinSync1_q, pinSync2_q;
  logic [7:0]  rowsSync1_q, rowsSync2_q;
  logic        shcpDly_q, stcpDly_q, oeDly_q;

  logic        dsSync, mrSync;
  logic        shcpRise, stcpRise, oeFall;
  logic        rowOneHot;

  logic [23:0] sr_q, sr_d;
  logic [23:0] latch_q, latch_d;
  logic [4:0]  shiftCount_q, shiftCount_d;
  logic [63:0] work_q, work_d;
  logic [7:0]  seen_q, seen_d;
  logic [7:0]  seenNext;
  logic [63:0] frame_q, frame_d;
  logic        frameValid_q, frameValid_d;
  logic        rowErr_q, rowErr_d;

  // Two-flop synchronizers for every asynchronous pin, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pinSync1_q  <= '0;
      pinSync2_q  <= '0;
      rowsSync1_q <= '0;
      rowsSync2_q <= '0;
    end else begin
      pinSync1_q  <= {ds, shcp, stcp, mr, oe};
      pinSync2_q  <= pinSync1_q;
      rowsSync1_q <= rows_in;
      rowsSync2_q <= rowsSync1_q;
    end
  end

  // Delayed copies of the synced clocks and oe, used to find their edges
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shcpDly_q <= 1'b0;
      stcpDly_q <= 1'b0;
      oeDly_q   <= 1'b0;
    end else begin
      shcpDly_q <= pinSync2_q[PinShcp];
      stcpDly_q <= pinSync2_q[PinStcp];
      oeDly_q   <= pinSync2_q[PinOe];
    end
  end

  // ds is taken from the same stage as shcp so data and shift clock line up
  assign dsSync   = pinSync2_q[PinDs];
  assign mrSync   = pinSync2_q[PinMr];
  assign shcpRise = pinSync2_q[PinShcp] & ~shcpDly_q;
  assign stcpRise = pinSync2_q[PinStcp] & ~stcpDly_q;
  assign oeFall   = ~pinSync2_q[PinOe] & oeDly_q;

  assign rowOneHot = (rowsSync2_q != 8'd0) &&
                     ((rowsSync2_q & (rowsSync2_q - 8'd1)) == 8'd0);

  // Shift chain, shift counter and storage latch; the latch copies the
  // pre-shift chain and an active mr clear overrides any shift
  always_comb begin
    sr_d         = sr_q;
    shiftCount_d = shiftCount_q;
    latch_d      = latch_q;
    if (stcpRise) begin
      latch_d = sr_q;
    end
    if (!mrSync) begin
      sr_d         = '0;
      shiftCount_d = '0;
    end else if (shcpRise) begin
      sr_d = {dsSync, sr_q[23:1]};
      if (shiftCount_q != 5'd31) begin
        shiftCount_d = shiftCount_q + 5'd1;
      end
    end
  end

  // Row capture on an oe fall; the frame is published with the row being
  // written in this very step folded in, and collection restarts
  always_comb begin
    work_d       = work_q;
    seen_d       = seen_q;
    seenNext     = seen_q;
    frame_d      = frame_q;
    frameValid_d = 1'b0;
    rowErr_d     = 1'b0;
    if (oeFall) begin
      if (rowOneHot) begin
        for (int r = 0; r < 8; r++) begin
          if (rowsSync2_q[r]) begin
            work_d[8*r +: 8] = latch_q[23:16];
          end
        end
        seenNext = seen_q | rowsSync2_q;
        if (seenNext == 8'hFF) begin
          frame_d      = work_d;
          frameValid_d = 1'b1;
          seen_d       = '0;
        end else begin
          seen_d = seenNext;
        end
      end else begin
        rowErr_d = 1'b1;
      end
    end
  end

  // State registers for the chain, latch and frame assembly
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q         <= '0;
      latch_q      <= '0;
      shiftCount_q <= '0;
      work_q       <= '0;
      seen_q       <= '0;
      frame_q      <= '0;
      frameValid_q <= 1'b0;
      rowErr_q     <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      latch_q      <= latch_d;
      shiftCount_q <= shiftCount_d;
      work_q       <= work_d;
      seen_q       <= seen_d;
      frame_q      <= frame_d;
      frameValid_q <= frameValid_d;
      rowErr_q     <= rowErr_d;
    end
  end

  assign latch_out   = latch_q;
  assign shift_count = shiftCount_q;
  assign frame_out   = frame_q;
  assign frame_valid = frameValid_q;
  assign row_err     = rowErr_q;

endmodule

// File: tb/tb_hc595_frame_capture.sv
// Directed testbench for hc595_frame_capture. Pins are driven on the falling
// clock edge and held for three clock periods so every level is seen by the
// synchronizers; outputs are checked on falling edges.
module tb_hc595_frame_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ds, shcp, stcp, mr, oe;
  logic [7:0]  rows_in;
  logic [23:0] latch_out;
  logic [4:0]  shift_count;
  logic [63:0] frame_out;
  logic        frame_valid;
  logic        row_err;

  int testCount = 0;
  int failCount = 0;
  int fvCount   = 0;
  int errCount  = 0;
  int fvBase;
  int errBase;

  hc595_frame_capture dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ds          (ds),
    .shcp        (shcp),
    .stcp        (stcp),
    .mr          (mr),
    .oe          (oe),
    .rows_in     (rows_in),
    .latch_out   (latch_out),
    .shift_count (shift_count),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .row_err     (row_err)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Count clock edges on which each pulse output is high
  always @(posedge clk) begin
    if (frame_valid === 1'b1) fvCount <= fvCount + 1;
    if (row_err === 1'b1) errCount <= errCount + 1;
  end

  // Guard against a run that never finishes
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shiftBit(input logic b);
    ds = b;
    waitCycles(3);
    shcp = 1'b1;
    waitCycles(3);
    shcp = 1'b0;
    waitCycles(3);
  endtask

  task automatic shiftValue(input logic [23:0] v, input int n);
    for (int i = 0; i < n; i++) shiftBit(v[i]);
  endtask

  task automatic pulseStcp();
    stcp = 1'b1;
    waitCycles(3);
    stcp = 1'b0;
    waitCycles(3);
  endtask

  task automatic captureMask(input logic [7:0] m);
    rows_in = m;
    waitCycles(3);
    oe = 1'b0;
    waitCycles(3);
    oe = 1'b1;
    waitCycles(3);
  endtask

  // Put byte b into latch[23:16] and capture it as row r
  task automatic applyStimulus(input int r, input logic [7:0] b);
    logic [7:0] m;
    m = 8'(1 << r);
    shiftValue({16'h0, b}, 8);
    pulseStcp();
    captureMask(m);
  endtask

  initial begin
    reset_n = 1'b0;
    ds = 1'b0; shcp = 1'b0; stcp = 1'b0; mr = 1'b1; oe = 1'b1;
    rows_in = 8'h00;
    waitCycles(3);

    // Reset state
    checkOutput("reset_latch", 64'(latch_out), 64'h0);
    checkOutput("reset_count", 64'(shift_count), 64'h0);
    checkOutput("reset_frame", frame_out, 64'h0);
    checkOutput("reset_valid", 64'(frame_valid), 64'h0);
    checkOutput("reset_err", 64'(row_err), 64'h0);
    reset_n = 1'b1;
    waitCycles(3);

    // 24-bit load and three-cycle latch latency
    shiftValue(24'hA50000, 24);
    checkOutput("load_count", 64'(shift_count), 64'd24);
    stcp = 1'b1;
    waitCycles(2);
    checkOutput("latch_latency_early", 64'(latch_out), 64'h0);
    waitCycles(1);
    checkOutput("latch_load", 64'(latch_out), 64'hA50000);
    stcp = 1'b0;
    waitCycles(3);

    // Full frame of walking ones
    fvBase = fvCount;
    for (int r = 0; r < 7; r++) applyStimulus(r, 8'(1 << r));
    checkOutput("frame_early_valid", 64'(fvCount - fvBase), 64'd0);
    checkOutput("frame_early_out", frame_out, 64'h0);
    applyStimulus(7, 8'h80);
    checkOutput("frame_valid_count", 64'(fvCount - fvBase), 64'd1);
    checkOutput("frame_walk", frame_out, 64'h8040201008040201);
    checkOutput("count_saturate", 64'(shift_count), 64'd31);

    // Clear priority over shifting
    mr = 1'b0;
    waitCycles(3);
    for (int i = 0; i < 5; i++) shiftBit(1'b1);
    checkOutput("clear_count", 64'(shift_count), 64'd0);
    pulseStcp();
    checkOutput("clear_sr", 64'(latch_out), 64'h0);
    mr = 1'b1;
    waitCycles(3);
    for (int i = 0; i < 3; i++) shiftBit(1'b1);
    checkOutput("after_clear_count", 64'(shift_count), 64'd3);
    pulseStcp();
    checkOutput("after_clear_sr", 64'(latch_out), 64'hE00000);

    // Bad row selects leave seen untouched
    fvBase  = fvCount;
    errBase = errCount;
    for (int r = 2; r < 8; r++) applyStimulus(r, 8'(8'h30 + r));
    captureMask(8'h03);
    captureMask(8'h00);
    checkOutput("bad_row_err", 64'(errCount - errBase), 64'd2);
    checkOutput("bad_row_valid", 64'(fvCount - fvBase), 64'd0);
    applyStimulus(0, 8'h30);
    checkOutput("bad_row_seen", 64'(fvCount - fvBase), 64'd0);
    applyStimulus(1, 8'h31);
    checkOutput("bad_row_publish", 64'(fvCount - fvBase), 64'd1);
    checkOutput("bad_row_frame", frame_out, 64'h3736353433323130);

    // Mid-frame reset discards the partial frame
    for (int r = 0; r < 4; r++) applyStimulus(r, 8'(8'h40 + r));
    reset_n = 1'b0;
    waitCycles(1);
    reset_n = 1'b1;
    checkOutput("midreset_frame", frame_out, 64'h0);
    checkOutput("midreset_latch", 64'(latch_out), 64'h0);
    checkOutput("midreset_count", 64'(shift_count), 64'd0);
    waitCycles(3);
    fvBase = fvCount;
    for (int r = 4; r < 8; r++) applyStimulus(r, 8'(8'h50 + r));
    checkOutput("midreset_no_valid", 64'(fvCount - fvBase), 64'd0);
    for (int r = 0; r < 4; r++) applyStimulus(r, 8'(8'h60 + r));
    checkOutput("midreset_valid", 64'(fvCount - fvBase), 64'd1);
    checkOutput("midreset_out", frame_out, 64'h5756555463626160);

    // Recapture of a row already seen overwrites it only
    fvBase = fvCount;
    applyStimulus(0, 8'h70);
    applyStimulus(0, 8'h71);
    checkOutput("recapture_valid", 64'(fvCount - fvBase), 64'd0);
    for (int r = 1; r < 8; r++) applyStimulus(r, 8'(8'h80 + r));
    checkOutput("recapture_publish", 64'(fvCount - fvBase), 64'd1);
    checkOutput("recapture_frame", frame_out, 64'h8786858483828171);

    // Shift and latch in the same cycle
    shiftValue(24'h123456, 24);
    ds = 1'b1;
    waitCycles(3);
    shcp = 1'b1;
    stcp = 1'b1;
    waitCycles(3);
    checkOutput("collide_latch", 64'(latch_out), 64'h123456);
    shcp = 1'b0;
    stcp = 1'b0;
    waitCycles(3);
    pulseStcp();
    checkOutput("collide_sr", 64'(latch_out), 64'h891A2B);

    // oe fall with stcp rise captures the pre-update latch
    fvBase = fvCount;
    shiftValue(24'h0000C3, 8);
    rows_in = 8'h01;
    waitCycles(3);
    oe   = 1'b0;
    stcp = 1'b1;
    waitCycles(3);
    oe   = 1'b1;
    stcp = 1'b0;
    waitCycles(3);
    for (int r = 1; r < 8; r++) captureMask(8'(1 << r));
    checkOutput("oe_stcp_publish", 64'(fvCount - fvBase), 64'd1);
    checkOutput("oe_stcp_frame", frame_out, 64'hC3C3C3C3C3C3C389);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
